// File: rtl/gray_mon_pkg.sv
// Shared definitions for the Gray-code step monitor.
//   state_t   : monitor state (IDLE = no previous sample, TRACK = checking,
//               ERROR = sticky fault, left only through Reset)
//   ERR_*     : values reported on Err_Code for the first detected fault
package gray_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_MULTI = 2'd1;
    localparam logic [1:0] ERR_BACK  = 2'd2;
    localparam logic [1:0] ERR_OVF   = 2'd3;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder.
//   gray : Gray-coded input, WIDTH bits
//   bin  : binary equivalent, WIDTH bits
// Each binary bit is the XOR of all Gray bits at or above its position,
// which is the closed form of bin[i] = bin[i+1] ^ gray[i].
module gray_to_bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bin[gi] = ^gray[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/gray_step_monitor.sv
// Monitor for an upstream Gray-code counter.
//   Clk         : clock, rising edge
//   Reset       : synchronous active-high reset (shared with the counter)
//   Gray_In     : Gray code from the counter
//   Overflow_In : counter overflow flag, rises with the first wrap to 0
//   Bin_Out     : registered binary decode of Gray_In (1-cycle latency)
//   Step_Valid  : one-cycle pulse after a legal +1 step (including wraps)
//   Wrap_Pulse  : one-cycle pulse after a legal max->0 step
//   Wrap_Count  : saturating count of legal wraps
//   Err         : sticky error flag
//   Err_Code    : cause of the first error (see gray_mon_pkg ERR_*)
module gray_step_monitor
    import gray_mon_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  Gray_In,
    input  logic              Overflow_In,
    output logic [WIDTH-1:0]  Bin_Out,
    output logic              Step_Valid,
    output logic              Wrap_Pulse,
    output logic [WRAP_W-1:0] Wrap_Count,
    output logic              Err,
    output logic [1:0]        Err_Code
);

    localparam logic [WIDTH-1:0]  BIN_MAX  = {WIDTH{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   prev_reg;
    logic               ovf_prev_reg;
    logic [WIDTH-1:0]   bin_reg;
    logic               step_reg, step_next;
    logic               wrap_reg, wrap_next;
    logic [WRAP_W-1:0]  wrap_cnt_reg, wrap_cnt_next;
    logic               err_reg, err_next;
    logic [1:0]         err_code_reg, err_code_next;

    logic [WIDTH-1:0]   bin_cur, bin_prev;
    logic [WIDTH-1:0]   diff;
    logic               one_bit, multi_bit;
    logic               is_wrap, is_inc, ovf_rise;
    logic               err_any;
    logic [1:0]         err_cause;

    gray_to_bin #(.WIDTH(WIDTH)) u_dec_cur  (.gray(Gray_In),  .bin(bin_cur));
    gray_to_bin #(.WIDTH(WIDTH)) u_dec_prev (.gray(prev_reg), .bin(bin_prev));

    // Transition classification against the previous sample.
    always_comb begin
        diff      = Gray_In ^ prev_reg;
        one_bit   = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
        multi_bit = (diff != '0) && !one_bit;
        is_wrap   = one_bit && (bin_prev == BIN_MAX) && (bin_cur == '0);
        is_inc    = one_bit && (bin_prev != BIN_MAX) && (bin_cur == bin_prev + WIDTH'(1));
        ovf_rise  = Overflow_In && !ovf_prev_reg;

        // Priority multi-bit > overflow > backward. A single-bit Gray change
        // that is not a forward step (a true -1, or a larger jump the Gray
        // code permits) is reported as a backward step.
        err_any   = 1'b1;
        err_cause = ERR_NONE;
        if (multi_bit) begin
            err_cause = ERR_MULTI;
        end else if ((is_wrap && !Overflow_In) || (ovf_rise && !is_wrap)) begin
            err_cause = ERR_OVF;
        end else if (one_bit && !is_wrap && !is_inc) begin
            err_cause = ERR_BACK;
        end else begin
            err_any = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = TRACK;
            TRACK:   if (err_any) state_next = ERROR;
            ERROR:   state_next = ERROR;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: values loaded into the output registers at the next edge.
    always_comb begin
        step_next     = 1'b0;
        wrap_next     = 1'b0;
        wrap_cnt_next = wrap_cnt_reg;
        err_next      = err_reg;
        err_code_next = err_code_reg;
        if (state_reg == TRACK) begin
            if (err_any) begin
                err_next      = 1'b1;
                err_code_next = err_cause;
            end else if (is_inc) begin
                step_next = 1'b1;
            end else if (is_wrap) begin
                step_next = 1'b1;
                wrap_next = 1'b1;
                if (wrap_cnt_reg != WRAP_MAX) begin
                    wrap_cnt_next = wrap_cnt_reg + WRAP_W'(1);
                end
            end
        end
    end

    // Datapath and output registers. prev/ovf history is captured every
    // cycle so IDLE naturally seeds TRACK with the first sample.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_reg     <= '0;
            ovf_prev_reg <= 1'b0;
            bin_reg      <= '0;
            step_reg     <= 1'b0;
            wrap_reg     <= 1'b0;
            wrap_cnt_reg <= '0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else begin
            prev_reg     <= Gray_In;
            ovf_prev_reg <= Overflow_In;
            bin_reg      <= bin_cur;
            step_reg     <= step_next;
            wrap_reg     <= wrap_next;
            wrap_cnt_reg <= wrap_cnt_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
        end
    end

    assign Bin_Out    = bin_reg;
    assign Step_Valid = step_reg;
    assign Wrap_Pulse = wrap_reg;
    assign Wrap_Count = wrap_cnt_reg;
    assign Err        = err_reg;
    assign Err_Code   = err_code_reg;

endmodule

// File: doc/gray_step_monitor.md
Name: gray_step_monitor

Overview:
- Sits directly downstream of the 3-bit Gray-code counter and consumes its Gray output and Overflow flag.
- Registers the binary equivalent of the Gray code and checks every transition for legal single-bit, count-up steps.
- Counts wrap events and captures the first protocol violation for debug and self-check.

Parameters:
- WIDTH, 3, width of the Gray code input and binary output.
- WRAP_W, 8, width of the saturating wrap counter.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset, shared with the upstream counter.
- Gray_In  input  WIDTH  Gray code from the upstream counter.
- Overflow_In  input  1  upstream overflow flag; rises in the same cycle Gray_In wraps to 0 and stays high until Reset.
- Bin_Out  output  WIDTH  registered binary decode of Gray_In.
- Step_Valid  output  1  one-cycle pulse for a legal +1 step.
- Wrap_Pulse  output  1  one-cycle pulse for a legal max->0 step.
- Wrap_Count  output  WRAP_W  number of legal wraps, saturates at all-ones.
- Err  output  1  sticky error flag.
- Err_Code  output  2  cause of the first error: 0 none, 1 multi-bit change, 2 backward step, 3 overflow mismatch.

Behaviour:
- Reset (synchronous, active-high) sets Bin_Out=0, Step_Valid=0, Wrap_Pulse=0, Wrap_Count=0, Err=0, Err_Code=0 and state IDLE. Reset overrides every other event in the same cycle.
- Decode: bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1]^g[i]. Bin_Out is the decode registered every cycle, so latency is 1 cycle.
- State IDLE (no previous sample): on the first non-reset cycle, capture prev=Gray_In and move to TRACK. No pulses and no checks in this cycle.
- State TRACK: compare Gray_In against prev each cycle, then set prev=Gray_In.
  - Equal (upstream En low): no pulse, no error.
  - Hamming distance >1: error code 1.
  - One bit changed, bin==prev_bin+1 with prev_bin!=max: Step_Valid=1 next cycle.
  - One bit changed, prev_bin==max and bin==0: a legal wrap only if Overflow_In==1 this cycle. Then Step_Valid=1 and Wrap_Pulse=1, and Wrap_Count increments unless it is all-ones.
  - One bit changed, bin==prev_bin-1 (mod 2^WIDTH): error code 2.
  - Wrap with Overflow_In==0: error code 3.
  - Overflow_In rising (0 in the previous cycle, 1 now) without a wrap transition this cycle: error code 3.
- State ERROR: entered from TRACK on any error. Err=1 and Err_Code latches the cause. If more than one cause occurs in the same cycle, priority is 1 > 3 > 2.
  - Bin_Out keeps decoding.
  - Step and wrap pulses are suppressed.
  - Wrap_Count freezes.
  - Only Reset leaves ERROR.
- Pulses are registered: asserted the cycle after the transition is sampled, for exactly one cycle.
- A reset mid-count puts both stages in the reset state together. The following 7->0 or x->0 jump is never checked, because the monitor is in IDLE.
- Overflow_In remaining high after a wrap is legal. Later wraps need only Overflow_In==1 in the wrap cycle.

Decomposition:
- Shared package gray_mon_pkg:
  - state enum IDLE/TRACK/ERROR.
  - Err_Code constants ERR_NONE, ERR_MULTI, ERR_BACK, ERR_OVF.
- One combinational sub-module, gray_to_bin (WIDTH parameter), instantiated twice: for Gray_In and for prev.

Test Plan:
- Reset 1 then 0, Gray_In steps 000,001,011,010,110,111,101,100 one per cycle -> Bin_Out 0..7, seven Step_Valid pulses, Err=0.
- Continue 100->000 with Overflow_In=1 in that cycle -> Wrap_Pulse=1 for one cycle, Wrap_Count=1, Bin_Out=0. A second full cycle with Overflow_In held high -> Wrap_Count=2.
- Gray_In held at 011 for 3 cycles (En low) -> no pulses, Err=0. Then step to 010 -> Step_Valid once.
- Gray_In jumps 001->010 -> Err=1, Err_Code=1 in the following cycle. Further legal steps produce no Step_Valid. Reset clears Err to 0.
- Gray_In 011->001 (backward) -> Err_Code=2. Separately, Overflow_In rises while Gray_In goes 001->011 -> Err_Code=3. Separately, 100->000 with Overflow_In=0 -> Err_Code=3.
- Reset asserted for 1 cycle while Gray_In=110, then Gray_In=000 -> no error. Counting then resumes and checks from 000.
